// File: rtl/alu_issue_queue_if.sv
// Shared uOP/queue-entry types and the dispatch/wakeup/issue bundle of the ALU issue queue.
package alu_iq_pkg;
  typedef logic [5:0] PRFNum;

  typedef struct packed {
    logic [3:0] alu_op;
    PRFNum      op0PAddr;
    PRFNum      op1PAddr;
    PRFNum      dstPAddr;
    logic [7:0] rob_idx;
  } UOPBundle;

  typedef struct packed {
    logic prs1_rdy;
    logic prs2_rdy;
  } ALU_Queue_Rdys;

  typedef struct packed {
    UOPBundle      ops;
    ALU_Queue_Rdys rdys;
  } ALU_Queue_Meta;
endpackage

interface alu_issue_queue_if
  import alu_iq_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WB_PORTS = 4
);
  logic                         enq_wen_0;
  logic                         enq_wen_1;
  ALU_Queue_Meta                enq_din_0;
  ALU_Queue_Meta                enq_din_1;
  logic [WB_PORTS-1:0]          wb_wen;
  PRFNum [WB_PORTS-1:0]         wb_num;
  logic                         issue_valid_0;
  logic                         issue_valid_1;
  UOPBundle                     issue_ops_0;
  UOPBundle                     issue_ops_1;
  logic                         issue_ready_0;
  logic                         issue_ready_1;
  logic                         full;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output enq_wen_0, enq_wen_1, enq_din_0, enq_din_1, wb_wen, wb_num,
    output issue_ready_0, issue_ready_1,
    input  issue_valid_0, issue_valid_1, issue_ops_0, issue_ops_1, full, count
  );

  modport slave (
    input  enq_wen_0, enq_wen_1, enq_din_0, enq_din_1, wb_wen, wb_num,
    input  issue_ready_0, issue_ready_1,
    output issue_valid_0, issue_valid_1, issue_ops_0, issue_ops_1, full, count
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Collapsing, age-ordered ALU reservation station: slot 0 is oldest, two oldest ready
// entries are offered to pipes 0/1, survivors shift down and new entries append.
module alu_issue_queue
  import alu_iq_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WB_PORTS = 4
)(
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  alu_issue_queue_if.slave q
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [DEPTH-1:0] rdy1_reg, rdy1_next;
  logic [DEPTH-1:0] rdy2_reg, rdy2_next;
  UOPBundle         ops_reg  [DEPTH];
  UOPBundle         ops_next [DEPTH];
  logic [CW-1:0]    count_reg, count_next, surv_cnt;

  function automatic logic wake_hit(input PRFNum paddr, input logic [WB_PORTS-1:0] wen,
                                    input PRFNum [WB_PORTS-1:0] num);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WB_PORTS; k++)
      if (wen[k] && num[k] == paddr) hit = 1'b1;
    return hit;
  endfunction

  logic [DEPTH-1:0] ready, wake1, wake2, removed, keep;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign ready[gi] = valid_reg[gi] & rdy1_reg[gi] & rdy2_reg[gi];
      assign wake1[gi] = wake_hit(ops_reg[gi].op0PAddr, q.wb_wen, q.wb_num);
      assign wake2[gi] = wake_hit(ops_reg[gi].op1PAddr, q.wb_wen, q.wb_num);
    end
  endgenerate

  logic din0_w1, din0_w2, din1_w1, din1_w2;
  assign din0_w1 = wake_hit(q.enq_din_0.ops.op0PAddr, q.wb_wen, q.wb_num);
  assign din0_w2 = wake_hit(q.enq_din_0.ops.op1PAddr, q.wb_wen, q.wb_num);
  assign din1_w1 = wake_hit(q.enq_din_1.ops.op0PAddr, q.wb_wen, q.wb_num);
  assign din1_w2 = wake_hit(q.enq_din_1.ops.op1PAddr, q.wb_wen, q.wb_num);

  // Oldest-first scan over registered readiness only; no wake-to-issue bypass.
  logic [IW-1:0] sel0, sel1;
  logic          found0, found1;
  always_comb begin
    found0 = 1'b0;
    found1 = 1'b0;
    sel0   = '0;
    sel1   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i]) begin
        if (!found0) begin
          found0 = 1'b1;
          sel0   = IW'(i);
        end else if (!found1) begin
          found1 = 1'b1;
          sel1   = IW'(i);
        end
      end
    end
  end

  assign q.issue_valid_0 = found0;
  assign q.issue_valid_1 = found1;
  assign q.issue_ops_0   = ops_reg[sel0];
  assign q.issue_ops_1   = ops_reg[sel1];

  logic rem0, rem1, full, enq0, enq1;
  assign rem0 = found0 & q.issue_ready_0;
  assign rem1 = found1 & q.issue_ready_1;

  always_comb begin
    removed = '0;
    if (rem0) removed[sel0] = 1'b1;
    if (rem1) removed[sel1] = 1'b1;
  end
  assign keep = valid_reg & ~removed;

  // Back-pressure uses the pre-issue count so dispatch never races a same-cycle dequeue.
  assign full     = count_reg > CW'(DEPTH - 2);
  assign enq0     = q.enq_wen_0 & ~full;
  assign enq1     = enq0 & q.enq_wen_1;
  assign surv_cnt = count_reg - CW'(rem0) - CW'(rem1);
  assign count_next = surv_cnt + CW'(enq0) + CW'(enq1);
  assign q.full   = full;
  assign q.count  = count_reg;

  always_comb begin
    int            shift;
    logic [IW-1:0] dst;
    valid_next = '0;
    rdy1_next  = '0;
    rdy2_next  = '0;
    shift      = 0;
    dst        = '0;
    for (int j = 0; j < DEPTH; j++) ops_next[j] = ops_reg[j];
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        dst             = IW'(i - shift);
        valid_next[dst] = 1'b1;
        ops_next[dst]   = ops_reg[i];
        rdy1_next[dst]  = rdy1_reg[i] | wake1[i];
        rdy2_next[dst]  = rdy2_reg[i] | wake2[i];
      end
      if (removed[i]) shift = shift + 1;
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (enq0 && CW'(j) == surv_cnt) begin
        valid_next[j] = 1'b1;
        ops_next[j]   = q.enq_din_0.ops;
        rdy1_next[j]  = q.enq_din_0.rdys.prs1_rdy | din0_w1;
        rdy2_next[j]  = q.enq_din_0.rdys.prs2_rdy | din0_w2;
      end
      if (enq1 && CW'(j) == surv_cnt + CW'(1)) begin
        valid_next[j] = 1'b1;
        ops_next[j]   = q.enq_din_1.ops;
        rdy1_next[j]  = q.enq_din_1.rdys.prs1_rdy | din1_w1;
        rdy2_next[j]  = q.enq_din_1.rdys.prs2_rdy | din1_w2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      rdy1_reg  <= '0;
      rdy2_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) ops_reg[i] <= '0;
    end else if (flush) begin
      valid_reg <= '0;
      count_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      rdy1_reg  <= rdy1_next;
      rdy2_reg  <= rdy2_next;
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) ops_reg[i] <= ops_next[i];
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: reset, wakeup, age order, full boundary,
// simultaneous issue/enqueue and flush.
module tb_alu_issue_queue;
  import alu_iq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  alu_issue_queue_if #(.DEPTH(8), .WB_PORTS(4)) bus();

  alu_issue_queue #(.DEPTH(8), .WB_PORTS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .q     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic ALU_Queue_Meta mk(input logic [7:0] id, input PRFNum p0, input PRFNum p1,
                                       input logic r1, input logic r2);
    ALU_Queue_Meta m;
    m = '0;
    m.ops.alu_op   = 4'h1;
    m.ops.op0PAddr = p0;
    m.ops.op1PAddr = p1;
    m.ops.dstPAddr = PRFNum'(id);
    m.ops.rob_idx  = id;
    m.rdys.prs1_rdy = r1;
    m.rdys.prs2_rdy = r2;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.enq_wen_0 = 1'b0;
    bus.enq_wen_1 = 1'b0;
    bus.enq_din_0 = '0;
    bus.enq_din_1 = '0;
    bus.wb_wen = '0;
    bus.wb_num = '0;
    bus.issue_ready_0 = 1'b0;
    bus.issue_ready_1 = 1'b0;
    flush = 1'b0;
  endtask

  // One enqueue cycle: drives the two dispatch slots, clocks once, returns to idle.
  task automatic enq(input logic w0, input ALU_Queue_Meta d0, input logic w1, input ALU_Queue_Meta d1);
    bus.enq_wen_0 = w0;
    bus.enq_din_0 = d0;
    bus.enq_wen_1 = w1;
    bus.enq_din_1 = d1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_cmp++; if (bus.issue_valid_0 !== 1'b0) begin n_fail++; $display("FAIL reset_iv0: got %b want 0", bus.issue_valid_0); end
    n_cmp++; if (bus.issue_valid_1 !== 1'b0) begin n_fail++; $display("FAIL reset_iv1: got %b want 0", bus.issue_valid_1); end
    enq(1'b1, mk(8'd1, 6'd60, 6'd61, 1'b0, 1'b1), 1'b1, mk(8'd2, 6'd60, 6'd61, 1'b0, 1'b1));
    enq(1'b1, mk(8'd3, 6'd60, 6'd61, 1'b0, 1'b1), 1'b1, mk(8'd4, 6'd60, 6'd61, 1'b0, 1'b1));
    enq(1'b1, mk(8'd5, 6'd60, 6'd61, 1'b0, 1'b1), 1'b0, '0);
    n_cmp++; if (bus.count !== 4'd5) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 5", bus.count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.issue_valid_0 !== 1'b0 || bus.issue_valid_1 !== 1'b0) begin n_fail++; $display("FAIL async_reset_iv: got %b%b want 00", bus.issue_valid_0, bus.issue_valid_1); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    enq(1'b1, mk(8'd7, 6'd0, 6'd0, 1'b1, 1'b1), 1'b0, '0);
    n_cmp++; if (bus.issue_valid_0 !== 1'b1) begin n_fail++; $display("FAIL basic_iv0: got %b want 1", bus.issue_valid_0); end
    n_cmp++; if (bus.issue_ops_0.rob_idx !== 8'd7) begin n_fail++; $display("FAIL basic_ops0: got %0d want 7", bus.issue_ops_0.rob_idx); end
    n_cmp++; if (bus.issue_valid_1 !== 1'b0) begin n_fail++; $display("FAIL basic_iv1: got %b want 0", bus.issue_valid_1); end
    bus.issue_ready_0 = 1'b1;
    tick();
    idle();
    n_cmp++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL basic_drain_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_wakeup();
    enq(1'b1, mk(8'd12, 6'd12, 6'd40, 1'b0, 1'b1), 1'b0, '0);
    n_cmp++; if (bus.issue_valid_0 !== 1'b0) begin n_fail++; $display("FAIL wake_n1_iv0: got %b want 0", bus.issue_valid_0); end
    tick();
    tick();
    bus.wb_wen[2] = 1'b1;
    bus.wb_num[2] = 6'd12;
    #1;
    n_cmp++; if (bus.issue_valid_0 !== 1'b0) begin n_fail++; $display("FAIL wake_same_cycle_iv0: got %b want 0", bus.issue_valid_0); end
    tick();
    idle();
    n_cmp++; if (bus.issue_valid_0 !== 1'b1 || bus.issue_ops_0.rob_idx !== 8'd12) begin n_fail++; $display("FAIL wake_n4: got v=%b id=%0d want v=1 id=12", bus.issue_valid_0, bus.issue_ops_0.rob_idx); end
    bus.issue_ready_0 = 1'b1;
    tick();
    idle();
    // Wakeup arriving together with the enqueue.
    bus.wb_wen[0] = 1'b1;
    bus.wb_num[0] = 6'd20;
    enq(1'b1, mk(8'd13, 6'd20, 6'd41, 1'b0, 1'b1), 1'b0, '0);
    n_cmp++; if (bus.issue_valid_0 !== 1'b1 || bus.issue_ops_0.rob_idx !== 8'd13) begin n_fail++; $display("FAIL wake_at_enq: got v=%b id=%0d want v=1 id=13", bus.issue_valid_0, bus.issue_ops_0.rob_idx); end
    bus.issue_ready_0 = 1'b1;
    tick();
    idle();
    n_cmp++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL wake_drain_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_age_order();
    enq(1'b1, mk(8'd10, 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, mk(8'd11, 6'd0, 6'd0, 1'b1, 1'b1));
    enq(1'b1, mk(8'd12, 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, mk(8'd13, 6'd0, 6'd0, 1'b1, 1'b1));
    tick();
    n_cmp++; if (bus.issue_ops_0.rob_idx !== 8'd10 || bus.issue_ops_1.rob_idx !== 8'd11 || !bus.issue_valid_1) begin n_fail++; $display("FAIL age_ab: got %0d/%0d want 10/11", bus.issue_ops_0.rob_idx, bus.issue_ops_1.rob_idx); end
    n_cmp++; if (bus.count !== 4'd4) begin n_fail++; $display("FAIL age_count4: got %0d want 4", bus.count); end
    bus.issue_ready_0 = 1'b1;
    tick();
    idle();
    n_cmp++; if (bus.issue_ops_0.rob_idx !== 8'd11 || bus.issue_ops_1.rob_idx !== 8'd12) begin n_fail++; $display("FAIL age_bc: got %0d/%0d want 11/12", bus.issue_ops_0.rob_idx, bus.issue_ops_1.rob_idx); end
    n_cmp++; if (bus.count !== 4'd3) begin n_fail++; $display("FAIL age_count3: got %0d want 3", bus.count); end
    bus.issue_ready_1 = 1'b1;
    tick();
    idle();
    n_cmp++; if (bus.issue_ops_0.rob_idx !== 8'd11 || bus.issue_ops_1.rob_idx !== 8'd13) begin n_fail++; $display("FAIL age_port1_only: got %0d/%0d want 11/13", bus.issue_ops_0.rob_idx, bus.issue_ops_1.rob_idx); end
    bus.issue_ready_0 = 1'b1;
    bus.issue_ready_1 = 1'b1;
    tick();
    idle();
    n_cmp++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL age_drain_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_full();
    enq(1'b1, mk(8'd20, 6'd30, 6'd31, 1'b0, 1'b1), 1'b1, mk(8'd21, 6'd30, 6'd31, 1'b0, 1'b1));
    enq(1'b1, mk(8'd22, 6'd30, 6'd31, 1'b0, 1'b1), 1'b1, mk(8'd23, 6'd30, 6'd31, 1'b0, 1'b1));
    enq(1'b1, mk(8'd24, 6'd30, 6'd31, 1'b0, 1'b1), 1'b1, mk(8'd25, 6'd30, 6'd31, 1'b0, 1'b1));
    n_cmp++; if (bus.count !== 4'd6 || bus.full !== 1'b0) begin n_fail++; $display("FAIL full_at6: got count=%0d full=%b want 6/0", bus.count, bus.full); end
    enq(1'b1, mk(8'd26, 6'd30, 6'd31, 1'b0, 1'b1), 1'b0, '0);
    n_cmp++; if (bus.count !== 4'd7 || bus.full !== 1'b1) begin n_fail++; $display("FAIL full_at7: got count=%0d full=%b want 7/1", bus.count, bus.full); end
    enq(1'b1, mk(8'd99, 6'd0, 6'd0, 1'b1, 1'b1), 1'b0, '0);
    n_cmp++; if (bus.count !== 4'd7) begin n_fail++; $display("FAIL full_enq_ignored_count: got %0d want 7", bus.count); end
    n_cmp++; if (bus.issue_valid_0 !== 1'b0) begin n_fail++; $display("FAIL full_enq_ignored_iv0: got %b want 0", bus.issue_valid_0); end
    bus.wb_wen[1] = 1'b1;
    bus.wb_num[1] = 6'd30;
    tick();
    idle();
    n_cmp++; if (bus.issue_ops_0.rob_idx !== 8'd20 || bus.issue_ops_1.rob_idx !== 8'd21 || !bus.issue_valid_1) begin n_fail++; $display("FAIL full_woken: got %0d/%0d want 20/21", bus.issue_ops_0.rob_idx, bus.issue_ops_1.rob_idx); end
    // Dequeue two while still full; the enqueue in that cycle must still be refused.
    bus.issue_ready_0 = 1'b1;
    bus.issue_ready_1 = 1'b1;
    bus.enq_wen_0 = 1'b1;
    bus.enq_din_0 = mk(8'd98, 6'd0, 6'd0, 1'b1, 1'b1);
    tick();
    idle();
    n_cmp++; if (bus.count !== 4'd5 || bus.full !== 1'b0) begin n_fail++; $display("FAIL full_release: got count=%0d full=%b want 5/0", bus.count, bus.full); end
    n_cmp++; if (bus.issue_ops_0.rob_idx !== 8'd22) begin n_fail++; $display("FAIL full_next_oldest: got %0d want 22", bus.issue_ops_0.rob_idx); end
    flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_simultaneous();
    enq(1'b1, mk(8'd40, 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, mk(8'd41, 6'd0, 6'd0, 1'b1, 1'b1));
    enq(1'b1, mk(8'd42, 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, mk(8'd43, 6'd0, 6'd0, 1'b1, 1'b1));
    enq(1'b1, mk(8'd44, 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, mk(8'd45, 6'd0, 6'd0, 1'b1, 1'b1));
    bus.issue_ready_0 = 1'b1;
    bus.issue_ready_1 = 1'b1;
    enq(1'b1, mk(8'd46, 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, mk(8'd47, 6'd0, 6'd0, 1'b1, 1'b1));
    n_cmp++; if (bus.count !== 4'd6) begin n_fail++; $display("FAIL simul_count: got %0d want 6", bus.count); end
    n_cmp++; if (bus.issue_ops_0.rob_idx !== 8'd42 || bus.issue_ops_1.rob_idx !== 8'd43) begin n_fail++; $display("FAIL simul_slots01: got %0d/%0d want 42/43", bus.issue_ops_0.rob_idx, bus.issue_ops_1.rob_idx); end
    bus.issue_ready_0 = 1'b1;
    bus.issue_ready_1 = 1'b1;
    tick();
    n_cmp++; if (bus.issue_ops_0.rob_idx !== 8'd44 || bus.issue_ops_1.rob_idx !== 8'd45 || bus.count !== 4'd4) begin n_fail++; $display("FAIL simul_slots23: got %0d/%0d c=%0d want 44/45 c=4", bus.issue_ops_0.rob_idx, bus.issue_ops_1.rob_idx, bus.count); end
    tick();
    n_cmp++; if (bus.issue_ops_0.rob_idx !== 8'd46 || bus.issue_ops_1.rob_idx !== 8'd47 || bus.count !== 4'd2) begin n_fail++; $display("FAIL simul_slots45: got %0d/%0d c=%0d want 46/47 c=2", bus.issue_ops_0.rob_idx, bus.issue_ops_1.rob_idx, bus.count); end
    tick();
    idle();
    n_cmp++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL simul_drain_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_flush();
    enq(1'b1, mk(8'd50, 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, mk(8'd51, 6'd0, 6'd0, 1'b1, 1'b1));
    enq(1'b1, mk(8'd52, 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, mk(8'd53, 6'd0, 6'd0, 1'b1, 1'b1));
    enq(1'b1, mk(8'd54, 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, mk(8'd55, 6'd0, 6'd0, 1'b1, 1'b1));
    flush = 1'b1;
    bus.issue_ready_0 = 1'b1;
    bus.issue_ready_1 = 1'b1;
    enq(1'b1, mk(8'd56, 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, mk(8'd57, 6'd0, 6'd0, 1'b1, 1'b1));
    n_cmp++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.issue_valid_0 !== 1'b0 || bus.issue_valid_1 !== 1'b0) begin n_fail++; $display("FAIL flush_iv: got %b%b want 00", bus.issue_valid_0, bus.issue_valid_1); end
    tick();
    n_cmp++; if (bus.count !== 4'd0 || bus.issue_valid_0 !== 1'b0) begin n_fail++; $display("FAIL flush_enq_absent: got count=%0d iv0=%b want 0/0", bus.count, bus.issue_valid_0); end
    enq(1'b1, mk(8'd58, 6'd0, 6'd0, 1'b1, 1'b1), 1'b0, '0);
    n_cmp++; if (bus.count !== 4'd1 || bus.issue_ops_0.rob_idx !== 8'd58) begin n_fail++; $display("FAIL flush_recover: got count=%0d id=%0d want 1/58", bus.count, bus.issue_ops_0.rob_idx); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    #12 rst_n = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_wakeup();
    test_age_order();
    test_full();
    test_simultaneous();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Collapsing, age-ordered ALU reservation station between `dispatch` and the two ALU pipes. Accepts up to two `ALU_Queue_Meta` entries per cycle from dispatch and tracks per-operand readiness via writeback wakeup. Each cycle it offers the two oldest fully-ready entries to ALU pipes 0/1 and removes them on handshake. Back-pressure to dispatch is a registered-state `full` flag.

## Interface
- `DEPTH`, 8: entry count; ≥4.
- `WB_PORTS`, 4: number of writeback wakeup buses.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear of all entries (mispredict/exception).
- `enq_wen_0`, `enq_wen_1` in 1 each: dispatch write enables (`rs_alu_wen_0/1`).
- `enq_din_0`, `enq_din_1` in `ALU_Queue_Meta` each: `.ops` UOPBundle, `.rdys.prs1_rdy/.prs2_rdy`.
- `wb_wen` in `WB_PORTS`: wakeup valid per bus.
- `wb_num` in `WB_PORTS`×`PRFNum`: destination physical register per bus.
- `issue_valid_0`, `issue_valid_1` out 1 each: entry offered to ALU pipe 0/1.
- `issue_ops_0`, `issue_ops_1` out `UOPBundle` each: offered uOP.
- `issue_ready_0`, `issue_ready_1` in 1 each: pipe accepts this cycle.
- `full` out 1: asserted when free entries < 2; dispatch stalls.
- `count` out `$clog2(DEPTH+1)`: occupied entries.

## Operation
- Storage: `DEPTH` slots, each {valid, ops, prs1_rdy, prs2_rdy}. Slot 0 is the oldest; valid slots are always contiguous from 0.
- Enqueue, when `!full`:
  - `enq_wen_0` writes `enq_din_0` at slot `count` (after removals, see below).
  - `enq_wen_1` writes `enq_din_1` at the next slot.
  - `enq_din_0` is older than `enq_din_1`.
  - `enq_wen_1` without `enq_wen_0` is ignored.
  - Any enqueue while `full` is ignored; no entry is written.
- Wakeup: for every valid slot, and for each incoming entry in the same cycle, `prsN_rdy` is set when any `wb_wen[k] && wb_num[k] == opNPAddr`. Set bits never clear.
- Select: an entry is ready when valid && prs1_rdy && prs2_rdy, using registered bits only.
  - Oldest ready entry goes to port 0; second-oldest ready entry goes to port 1.
  - If fewer than two entries are ready, the unused port drives `issue_valid` = 0.
  - `issue_ops` is don't-care when `issue_valid` = 0.
- Removal: a slot leaves the queue when `issue_valid_k && issue_ready_k`. Ports handshake independently. A non-accepted entry keeps its slot and is re-offered next cycle, re-evaluated by age.
- Compaction: surviving slots shift down by the number of removed older entries (0–2). Enqueues append after the survivors. Age order is preserved.
- `full` = (`count` > `DEPTH`−2), from registered `count`.
- Priority: reset > `flush` > normal update.
  - `flush` clears all valid bits and sets `count` = 0.
  - Enqueue, issue handshake and wakeup in a flush cycle are discarded.

## Timing
- Reset (async on `rst_n` low): all valid = 0, `count` = 0, `full` = 0, `issue_valid_0/1` = 0. Deassertion is synchronized externally.
- Enqueue at cycle N: entry is visible in `count` and can be selected at N+1.
  - If its operands were ready at dispatch, or woken in cycle N, `issue_valid` is asserted at N+1.
- Wakeup at cycle N for an entry already in the queue: earliest issue at N+1. There is no same-cycle wake-to-issue path.
- `issue_valid`/`issue_ops` are combinational from registered state only. They do not depend on `issue_ready`, `enq_*` or `wb_*`.
- Simultaneous issue of 2 and enqueue of 2 with `count` = `DEPTH`−2 is accepted. `count` is unchanged.
- `full` reflects the pre-issue count. A same-cycle dequeue does not unblock dispatch until the next cycle.

## Test plan
- **Reset/basic:** assert `rst_n`=0 mid-run with 5 entries → `count`=0, `issue_valid_0/1`=0 immediately. Enqueue one ready ADD at N → `issue_valid_0`=1 at N+1; `issue_ready_0`=1 → `count`=0 at N+2.
- **Wakeup:** enqueue `enq_din_0` with op0PAddr=12, prs1_rdy=0, prs2_rdy=1 at N. Drive `wb_wen[2]`=1, `wb_num[2]`=12 at N+3 → `issue_valid_0` first high at N+4. Same wakeup in cycle N itself → issue at N+1.
- **Age order:** enqueue A,B at N and C,D at N+1, all ready, with `issue_ready_*`=0 for two cycles → ports show A/B. Then `issue_ready_0`=1 only → A leaves; next cycle ports show B/C.
- **Full boundary (`DEPTH`=8):** fill to 7 → `full`=1. `enq_wen_0`=1 while full → `count` stays 7, no write. Issue 2 → `full`=0 one cycle later.
- **Simultaneous:** `count`=6, two issues accepted and two enqueues in the same cycle → `count`=6, survivors compacted to slots 0–3, new entries in slots 4–5.
- **Flush:** `flush`=1 with 6 entries plus an enqueue plus an issue handshake → next cycle `count`=0, `issue_valid_*`=0, enqueued entries absent.
